// File: rtl/scpad_pkg.sv
// Shared scratchpad widths and the request/response/metadata types that move
// between the head, stomach and tail stages of a scratchpad bank.
package scpad_pkg;

    localparam int SCPAD_ID_WIDTH   = 2;
    localparam int NUM_SCPADS       = 1 << SCPAD_ID_WIDTH;
    localparam int SCPAD_ADDR_WIDTH = 10;
    localparam int SCPAD_ROW_WIDTH  = 64;
    localparam int MAX_READ_LAT     = 4;

    typedef enum logic {
        SRC_FE = 1'b0,
        SRC_BE = 1'b1
    } src_t;

    typedef struct packed {
        logic                        valid;
        logic                        write;
        src_t                        src;
        logic [SCPAD_ADDR_WIDTH-1:0] addr;
        logic [SCPAD_ROW_WIDTH-1:0]  wdata;
    } sel_req_t;

    typedef struct packed {
        logic                       valid;
        logic                       write;
        src_t                       src;
        logic [SCPAD_ROW_WIDTH-1:0] rdata;
    } sel_res_t;

    typedef struct packed {
        logic valid;
        logic write;
        src_t src;
    } stomach_meta_t;

    // Counter width able to hold 0..lat outstanding requests.
    function automatic int outstanding_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/scpad_if.sv
// Per-bank handshake bundle between head, stomach and tail; every signal is
// arrayed by bank index so all banks share one interface instance.
interface scpad_if;
    import scpad_pkg::*;

    sel_req_t head_stomach_req   [NUM_SCPADS];
    logic     head_stomach_ready [NUM_SCPADS];
    sel_res_t stomach_tail_res   [NUM_SCPADS];
    logic     stomach_idle       [NUM_SCPADS];

    modport spad_stomach (
        input  head_stomach_req,
        output head_stomach_ready,
        output stomach_tail_res,
        output stomach_idle
    );

    modport slave (
        input  head_stomach_req,
        output head_stomach_ready,
        output stomach_tail_res,
        output stomach_idle
    );

    modport master (
        output head_stomach_req,
        input  head_stomach_ready,
        input  stomach_tail_res,
        input  stomach_idle
    );

endinterface

// File: rtl/latch.sv
// Single pipeline register of any packed type, cleared asynchronously so that
// in-flight metadata vanishes the moment reset asserts.
module latch #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic n_rst,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/stomach.sv
// Scratchpad bank stomach: issues accepted head requests straight to the SRAM
// and re-times their metadata so every response meets its read data READ_LAT later.
module stomach
    import scpad_pkg::*;
#(
    parameter logic [SCPAD_ID_WIDTH-1:0] IDX      = '0,
    parameter int                        READ_LAT = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    scpad_if.spad_stomach               spad,
    output logic                        sram_en,
    output logic                        sram_we,
    output logic [SCPAD_ADDR_WIDTH-1:0] sram_addr,
    output logic [SCPAD_ROW_WIDTH-1:0]  sram_wdata,
    input  logic [SCPAD_ROW_WIDTH-1:0]  sram_rdata,
    input  logic                        sram_busy
);

    localparam int CNT_W = outstanding_width(READ_LAT);

    sel_req_t      req;
    sel_res_t      tail_res;
    logic          ready;
    logic          accept;
    logic          respond;
    stomach_meta_t meta_in;
    stomach_meta_t stage [READ_LAT];
    stomach_meta_t last;

    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;

    assign req   = spad.head_stomach_req[IDX];
    assign ready = !sram_busy;

    // Ready ignores reset, but nothing may be accepted while reset is held.
    assign accept = req.valid && ready && n_rst;

    assign spad.head_stomach_ready[IDX] = ready;

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (accept) begin
            sram_en    = 1'b1;
            sram_we    = req.write;
            sram_addr  = req.addr;
            sram_wdata = req.wdata;
        end
    end

    always_comb begin
        meta_in = '0;
        if (accept) begin
            meta_in.valid = 1'b1;
            meta_in.write = req.write;
            meta_in.src   = req.src;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                latch #(.T(stomach_meta_t)) u_latch (
                    .clk   (clk),
                    .n_rst (n_rst),
                    .d     (meta_in),
                    .q     (stage[gi])
                );
            end else begin : g_body
                latch #(.T(stomach_meta_t)) u_latch (
                    .clk   (clk),
                    .n_rst (n_rst),
                    .d     (stage[gi-1]),
                    .q     (stage[gi])
                );
            end
        end
    endgenerate

    assign last    = stage[READ_LAT-1];
    assign respond = last.valid;

    // Read data is only meaningful in the cycle a read's metadata surfaces.
    always_comb begin
        tail_res       = '0;
        tail_res.valid = last.valid;
        tail_res.write = last.write;
        tail_res.src   = last.src;
        if (last.valid && !last.write) begin
            tail_res.rdata = sram_rdata;
        end
    end

    assign spad.stomach_tail_res[IDX] = tail_res;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !respond) begin
            outstanding_next = outstanding_reg + CNT_W'(1);
        end else if (!accept && respond) begin
            outstanding_next = outstanding_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
        end
    end

    assign spad.stomach_idle[IDX] = (outstanding_reg == '0) && !req.valid;

endmodule

// File: tb/tb_stomach.sv
// Scoreboard bench for stomach: banks 0/1/2 run READ_LAT 2/1/4 on one shared
// scpad_if, each with a behavioural SRAM that returns data after its latency.
`timescale 1ns/1ps
module tb_stomach;
    import scpad_pkg::*;

    localparam int NB = 3;
    localparam int AW = SCPAD_ADDR_WIDTH;
    localparam int RW = SCPAD_ROW_WIDTH;
    localparam logic [RW-1:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [RW-1:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;

    typedef struct {
        int          bank;
        int          due;
        logic        write;
        src_t        src;
        logic [RW-1:0] rdata;
    } exp_t;

    logic          clk;
    logic          n_rst;
    logic          sram_en    [NB];
    logic          sram_we    [NB];
    logic [AW-1:0] sram_addr  [NB];
    logic [RW-1:0] sram_wdata [NB];
    logic [RW-1:0] sram_rdata [NB];
    logic          sram_busy  [NB];

    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q [$];

    scpad_if sif ();

    stomach #(.IDX(2'd0), .READ_LAT(2)) u_bank0 (
        .clk(clk), .n_rst(n_rst), .spad(sif.spad_stomach),
        .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]), .sram_busy(sram_busy[0])
    );
    stomach #(.IDX(2'd1), .READ_LAT(1)) u_bank1 (
        .clk(clk), .n_rst(n_rst), .spad(sif.spad_stomach),
        .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]), .sram_busy(sram_busy[1])
    );
    stomach #(.IDX(2'd2), .READ_LAT(4)) u_bank2 (
        .clk(clk), .n_rst(n_rst), .spad(sif.spad_stomach),
        .sram_en(sram_en[2]), .sram_we(sram_we[2]), .sram_addr(sram_addr[2]),
        .sram_wdata(sram_wdata[2]), .sram_rdata(sram_rdata[2]), .sram_busy(sram_busy[2])
    );

    assign sif.head_stomach_ready[3] = 1'b0;
    assign sif.stomach_tail_res[3]   = '0;
    assign sif.stomach_idle[3]       = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
        if (a == AW'(16)) return A5;
        return {22'h0, a, 32'h5EED_0000 | {22'h0, a}};
    endfunction

    function automatic int lat_of(input int b);
        case (b)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int get_out(input int b);
        case (b)
            0:       return int'(u_bank0.outstanding_reg);
            1:       return int'(u_bank1.outstanding_reg);
            default: return int'(u_bank2.outstanding_reg);
        endcase
    endfunction

    // Behavioural SRAM per bank: data for a read strobe appears L cycles later.
    for (genvar gi = 0; gi < NB; gi++) begin : g_sram
        localparam int L = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        logic [RW-1:0] mem [1 << AW];
        logic          rv  [L];
        logic [AW-1:0] ra  [L];
        initial begin
            for (int a = 0; a < (1 << AW); a++) mem[a] <= pat(AW'(a));
            for (int k = 0; k < L; k++) begin
                rv[k] <= 1'b0;
                ra[k] <= '0;
            end
        end
        always @(posedge clk) begin
            if (sram_en[gi] && sram_we[gi]) mem[sram_addr[gi]] <= sram_wdata[gi];
            rv[0] <= sram_en[gi] && !sram_we[gi];
            ra[0] <= sram_addr[gi];
            for (int k = 1; k < L; k++) begin
                rv[k] <= rv[k-1];
                ra[k] <= ra[k-1];
            end
        end
        assign sram_rdata[gi] = rv[L-1] ? mem[ra[L-1]] : JUNK;
    end

    // Response monitor: pops the oldest expectation of each bank.
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            sel_res_t r;
            int       idx;
            exp_t     e;
            r   = sif.stomach_tail_res[b];
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].bank == b) begin
                    idx = i;
                    break;
                end
            end
            if (r.valid === 1'b1) begin
                n_cmp++;
                if (idx < 0) begin
                    n_bad++;
                    $display("FAIL resp_unexpected bank%0d cyc=%0d got write=%b src=%0d rdata=%h required no response",
                             b, cyc, r.write, r.src, r.rdata);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    if (cyc !== e.due || r.write !== e.write || r.src !== e.src || r.rdata !== e.rdata) begin
                        n_bad++;
                        $display("FAIL resp_fields bank%0d got cyc=%0d write=%b src=%0d rdata=%h required cyc=%0d write=%b src=%0d rdata=%h",
                                 b, cyc, r.write, r.src, r.rdata, e.due, e.write, e.src, e.rdata);
                    end else begin
                        $display("resp bank%0d cyc=%0d write=%b src=%0d rdata=%h ok", b, cyc, r.write, r.src, r.rdata);
                    end
                end
            end else if (idx >= 0 && exp_q[idx].due <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_missing bank%0d got no response at cyc=%0d required one due at cyc=%0d",
                         b, cyc, exp_q[idx].due);
                exp_q.delete(idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int b, input logic v, input logic w, input src_t s,
                         input logic [AW-1:0] a, input logic [RW-1:0] d);
        sif.head_stomach_req[b] = '{valid: v, write: w, src: s, addr: a, wdata: d};
    endtask

    task automatic push(input int b, input logic w, input src_t s, input logic [RW-1:0] d);
        exp_q.push_back('{bank: b, due: cyc + lat_of(b), write: w, src: s, rdata: d});
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        drive(0, 1'b1, 1'b0, SRC_FE, AW'(3), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sif.head_stomach_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got %b required 1", sif.head_stomach_ready[0]);
        end
        n_cmp++;
        if (sram_en[0] !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_accept got sram_en=%b required 0", sram_en[0]);
        end
        n_cmp++;
        if (sif.stomach_tail_res[0] !== '0) begin
            n_bad++; $display("FAIL reset_res got %h required 0", sif.stomach_tail_res[0]);
        end
        n_cmp++;
        if (get_out(0) !== 0) begin
            n_bad++; $display("FAIL reset_outstanding got %0d required 0", get_out(0));
        end
        sram_busy[0] = 1'b1;
        #1;
        n_cmp++;
        if (sif.head_stomach_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy_ready got %b required 0", sif.head_stomach_ready[0]);
        end
        sram_busy[0] = 1'b0;
        drive(0, 1'b0, 1'b0, SRC_FE, '0, '0);
        step();
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_read(input int b);
        drive(b, 1'b1, 1'b0, SRC_FE, AW'(16), RW'(1));
        push(b, 1'b0, SRC_FE, A5);
        @(negedge clk);
        n_cmp++;
        if (sram_en[b] !== 1'b1 || sram_we[b] !== 1'b0 || sram_addr[b] !== AW'(16) || sram_wdata[b] !== RW'(1)) begin
            n_bad++;
            $display("FAIL read_issue bank%0d got en=%b we=%b addr=%h wdata=%h required en=1 we=0 addr=010 wdata=1",
                     b, sram_en[b], sram_we[b], sram_addr[b], sram_wdata[b]);
        end
        step();
        drive(b, 1'b0, 1'b0, SRC_FE, AW'(16), RW'(1));
        @(negedge clk);
        n_cmp++;
        if (sram_en[b] !== 1'b0 || sram_addr[b] !== '0 || sram_wdata[b] !== '0) begin
            n_bad++;
            $display("FAIL read_quiet bank%0d got en=%b addr=%h wdata=%h required all 0",
                     b, sram_en[b], sram_addr[b], sram_wdata[b]);
        end
        repeat (lat_of(b) + 1) step();
    endtask

    task automatic test_write_then_read();
        logic [RW-1:0] w;
        w = 64'h0123_4567_89AB_CDEF;
        drive(0, 1'b1, 1'b1, SRC_BE, AW'(32), w);
        push(0, 1'b1, SRC_BE, '0);
        @(negedge clk);
        n_cmp++;
        if (sram_en[0] !== 1'b1 || sram_we[0] !== 1'b1 || sram_wdata[0] !== w) begin
            n_bad++;
            $display("FAIL write_issue got en=%b we=%b wdata=%h required en=1 we=1 wdata=%h",
                     sram_en[0], sram_we[0], sram_wdata[0], w);
        end
        step();
        drive(0, 1'b1, 1'b0, SRC_FE, AW'(32), '0);
        push(0, 1'b0, SRC_FE, w);
        @(negedge clk);
        n_cmp++;
        if (sram_en[0] !== 1'b1 || sram_we[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_rd_issue got en=%b we=%b required en=1 we=0", sram_en[0], sram_we[0]);
        end
        step();
        drive(0, 1'b0, 1'b0, SRC_FE, '0, '0);
        repeat (4) step();
    endtask

    task automatic test_back_to_back(input int b);
        int peak;
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            src_t s;
            s = (i % 2 == 0) ? SRC_FE : SRC_BE;
            drive(b, 1'b1, 1'b0, s, AW'(48 + i), '0);
            push(b, 1'b0, s, pat(AW'(48 + i)));
            @(negedge clk);
            if (get_out(b) > peak) peak = get_out(b);
            n_cmp++;
            if (sif.stomach_idle[b] !== 1'b0) begin
                n_bad++; $display("FAIL b2b_idle_busy bank%0d got %b required 0", b, sif.stomach_idle[b]);
            end
            step();
        end
        drive(b, 1'b0, 1'b0, SRC_FE, '0, '0);
        for (int i = 0; i < lat_of(b) + 2; i++) begin
            @(negedge clk);
            if (get_out(b) > peak) peak = get_out(b);
            step();
        end
        @(negedge clk);
        n_cmp++;
        if (peak !== lat_of(b)) begin
            n_bad++; $display("FAIL b2b_peak bank%0d got %0d required %0d", b, peak, lat_of(b));
        end
        n_cmp++;
        if (get_out(b) !== 0 || sif.stomach_idle[b] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_drain bank%0d got outstanding=%0d idle=%b required 0 and 1",
                     b, get_out(b), sif.stomach_idle[b]);
        end
        step();
    endtask

    task automatic test_busy();
        drive(0, 1'b1, 1'b0, SRC_FE, AW'(64), '0);
        push(0, 1'b0, SRC_FE, pat(AW'(64)));
        step();
        sram_busy[0] = 1'b1;
        drive(0, 1'b1, 1'b0, SRC_BE, AW'(65), '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sif.head_stomach_ready[0] !== 1'b0 || sram_en[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_block cycle%0d got ready=%b en=%b required 0 and 0",
                         i, sif.head_stomach_ready[0], sram_en[0]);
            end
            step();
        end
        sram_busy[0] = 1'b0;
        push(0, 1'b0, SRC_BE, pat(AW'(65)));
        @(negedge clk);
        n_cmp++;
        if (sif.head_stomach_ready[0] !== 1'b1 || sram_en[0] !== 1'b1 || sram_addr[0] !== AW'(65)) begin
            n_bad++;
            $display("FAIL busy_release got ready=%b en=%b addr=%h required 1 1 041",
                     sif.head_stomach_ready[0], sram_en[0], sram_addr[0]);
        end
        step();
        drive(0, 1'b0, 1'b0, SRC_FE, '0, '0);
        repeat (4) step();
    endtask

    task automatic test_reset_inflight();
        drive(2, 1'b1, 1'b0, SRC_FE, AW'(80), '0);
        step();
        drive(2, 1'b1, 1'b0, SRC_FE, AW'(81), '0);
        step();
        drive(2, 1'b0, 1'b0, SRC_FE, '0, '0);
        #1 n_rst = 1'b0;
        #1;
        n_cmp++;
        if (get_out(2) !== 0 || sif.stomach_idle[2] !== 1'b1 || sif.stomach_tail_res[2].valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flush got outstanding=%0d idle=%b valid=%b required 0 1 0",
                     get_out(2), sif.stomach_idle[2], sif.stomach_tail_res[2].valid);
        end
        step();
        n_rst = 1'b1;
        repeat (6) step();
        drive(2, 1'b1, 1'b0, SRC_BE, AW'(82), '0);
        push(2, 1'b0, SRC_BE, pat(AW'(82)));
        step();
        drive(2, 1'b0, 1'b0, SRC_FE, '0, '0);
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < NUM_SCPADS; k++) sif.head_stomach_req[k] = '0;
        for (int k = 0; k < NB; k++) sram_busy[k] = 1'b0;

        test_reset();
        for (int b = 0; b < NB; b++) test_read(b);
        test_write_then_read();
        test_back_to_back(0);
        test_back_to_back(2);
        test_busy();
        test_reset_inflight();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d responses still pending required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
